// File: rtl/useq_pkg.sv
// Shared definitions for the micro-sequencer: next-address modes and microword field offsets.
// Microword layout, MSB first: MODE | SELA | SELB | T0 | T1 | T2 | T3 | CTRL.
package useq_pkg;

    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_CALL   = 2'b01;
    localparam logic [1:0] MODE_RET    = 2'b10;
    localparam logic [1:0] MODE_WAIT   = 2'b11;

    function automatic int sel_width(input int ncond);
        return $clog2(ncond);
    endfunction

    function automatic int uw_width(input int addr_w, input int ctrl_w, input int ncond);
        return 2 + 2 * sel_width(ncond) + 4 * addr_w + ctrl_w;
    endfunction

    // Target k (0..3) sits above CTRL, with T3 lowest and T0 highest.
    function automatic int tgt_lsb(input int addr_w, input int ctrl_w, input int k);
        return ctrl_w + (3 - k) * addr_w;
    endfunction

    function automatic int tgt_msb(input int addr_w, input int ctrl_w, input int k);
        return tgt_lsb(addr_w, ctrl_w, k) + addr_w - 1;
    endfunction

    function automatic int selb_lsb(input int addr_w, input int ctrl_w);
        return ctrl_w + 4 * addr_w;
    endfunction

    function automatic int sela_lsb(input int addr_w, input int ctrl_w, input int ncond);
        return selb_lsb(addr_w, ctrl_w) + sel_width(ncond);
    endfunction

    function automatic int mode_lsb(input int addr_w, input int ctrl_w, input int ncond);
        return sela_lsb(addr_w, ctrl_w, ncond) + sel_width(ncond);
    endfunction

    function automatic int mode_msb(input int addr_w, input int ctrl_w, input int ncond);
        return mode_lsb(addr_w, ctrl_w, ncond) + 1;
    endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the micro-sequencer; push/pop are ignored when full/empty.
module useq_stack #(
    parameter int DEPTH = 2,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];

    assign full  = (ptr_q == PTR_W'(DEPTH));
    assign empty = (ptr_q == '0);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        ptr_d = ptr_q;
        mem_d = mem_q;
        top   = '0;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ptr_q == PTR_W'(i)) mem_d[i] = din;
            end
            ptr_d = ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == PTR_W'(i + 1)) top = mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // NOTE: storage is not reset; the pointer alone defines which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the micro-PC, decodes the next-address field of the ROM word
// (branch, call/return, wait) and gates the control field onto the datapath bus.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int CTRL_W      = 22,
    parameter int NCOND       = 4,
    parameter int STACK_DEPTH = 2,
    parameter int RESET_ADDR  = 0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      stall,
    input  logic [NCOND-1:0]                          cond,
    output logic [ADDR_W-1:0]                         uaddr,
    input  logic [uw_width(ADDR_W, CTRL_W, NCOND)-1:0] uword,
    output logic [CTRL_W-1:0]                         bus_ctrl,
    output logic                                      stack_ovf,
    output logic                                      stack_unf
);

    localparam int SEL_W   = sel_width(NCOND);
    localparam int MODE_LO = mode_lsb(ADDR_W, CTRL_W, NCOND);
    localparam int SELA_LO = sela_lsb(ADDR_W, CTRL_W, NCOND);
    localparam int SELB_LO = selb_lsb(ADDR_W, CTRL_W);

    logic [1:0]        mode;
    logic [SEL_W-1:0]  sela, selb;
    logic [ADDR_W-1:0] tgt [4];
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        br_idx;

    assign mode   = uword[MODE_LO +: 2];
    assign sela   = uword[SELA_LO +: SEL_W];
    assign selb   = uword[SELB_LO +: SEL_W];
    assign tgt[0] = uword[tgt_lsb(ADDR_W, CTRL_W, 0) +: ADDR_W];
    assign tgt[1] = uword[tgt_lsb(ADDR_W, CTRL_W, 1) +: ADDR_W];
    assign tgt[2] = uword[tgt_lsb(ADDR_W, CTRL_W, 2) +: ADDR_W];
    assign tgt[3] = uword[tgt_lsb(ADDR_W, CTRL_W, 3) +: ADDR_W];
    assign ctrl   = uword[CTRL_W-1:0];
    assign br_idx = {cond[sela], cond[selb]};

    // The datapath must see no control activity while frozen or held in reset.
    assign bus_ctrl = (stall || !rst_n) ? '0 : ctrl;

    logic [ADDR_W-1:0] uaddr_q, uaddr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (tgt[1]),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        uaddr_d  = uaddr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (!stall) begin
            case (mode)
                MODE_BRANCH: uaddr_d = tgt[br_idx];
                MODE_CALL: begin
                    uaddr_d = tgt[0];
                    if (stk_full) ovf_d    = 1'b1;
                    else          stk_push = 1'b1;
                end
                MODE_RET: begin
                    if (stk_empty) begin
                        uaddr_d = tgt[0];
                        unf_d   = 1'b1;
                    end else begin
                        uaddr_d = stk_top;
                        stk_pop = 1'b1;
                    end
                end
                MODE_WAIT: uaddr_d = cond[sela] ? uaddr_q : tgt[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uaddr_q <= ADDR_W'(RESET_ADDR);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            uaddr_q <= uaddr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign uaddr     = uaddr_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule
